adc_capture: RTL

Multi-channel, time-stamped sampling and capture block for the emulated receive path. Samples up to N_CH fixed-point analog channels whenever emulated time crosses a programmable sample instant, quantizes each to an ADC code, and buffers code plus timestamp in an on-chip FIFO. The host-side readout logic drains the FIFO over a valid/ready handshake. It supersedes single-channel debug-only sampling.

---
 rtl/adc_capture_pkg.sv | 15 +
 rtl/adc_quantize.sv | 33 +++
 rtl/adc_capture.sv | 132 +++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the emulated-time ADC capture path: time format and capture FSM states.
package adc_capture_pkg;

   localparam int unsigned TIME_BITS = 32;

   typedef logic [TIME_BITS-1:0] time_format_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } adc_state_e;

endpackage

// File: rtl/adc_quantize.sv
// One channel of fixed-point to ADC-code conversion: round half up, then saturate.
module adc_quantize #(
   parameter int unsigned SIG_BITS = 16,
   parameter int unsigned OUT_BITS = 8
) (
   input  logic [SIG_BITS-1:0] sample,
   output logic [OUT_BITS-1:0] code_c
);

   localparam int unsigned SHIFT = SIG_BITS - OUT_BITS;

   if (SHIFT == 0) begin : g_pass
      assign code_c = OUT_BITS'(sample);
   end else begin : g_round
      localparam logic signed [SIG_BITS:0] HALF = (SIG_BITS+1)'(1) << (SHIFT - 1);
      localparam logic [OUT_BITS-1:0] CODE_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
      localparam logic [OUT_BITS-1:0] CODE_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

      logic signed [SIG_BITS:0] sum_c;
      logic signed [SIG_BITS:0] shr_c;

      // One guard bit keeps the rounding add from wrapping at full scale
      assign sum_c = $signed({sample[SIG_BITS-1], sample}) + HALF;
      assign shr_c = sum_c >>> SHIFT;

      always_comb begin
         code_c = shr_c[OUT_BITS-1:0];
         if (shr_c[SIG_BITS:OUT_BITS-1] != {(SHIFT+2){shr_c[SIG_BITS]}})
            code_c = shr_c[SIG_BITS] ? CODE_MIN : CODE_MAX;
      end
   end

endmodule

// File: rtl/adc_capture.sv
// Time-stamped multi-channel sampler: captures quantized codes whenever emulated time reaches
// the next sample instant and buffers them with their timestamp for valid/ready readout.
module adc_capture
   import adc_capture_pkg::*;
#(
   parameter int unsigned N_CH      = 1,
   parameter int unsigned SIG_BITS  = 16,
   parameter int unsigned SIG_POINT = 14,
   parameter int unsigned OUT_BITS  = 8,
   parameter int unsigned DEPTH     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  time_format_t               time_curr,
   input  logic [N_CH*SIG_BITS-1:0]   sig,
   input  time_format_t               t_period,
   input  logic                       mode,
   input  logic                       arm,
   input  logic                       abort,
   input  logic                       flush,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [N_CH*OUT_BITS-1:0]   rd_data,
   output time_format_t               rd_time,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                overflow,
   output logic [1:0]                 state
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = N_CH * OUT_BITS;
   localparam int unsigned EW = DW + TIME_BITS;

   if (SIG_POINT >= SIG_BITS || OUT_BITS > SIG_BITS || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0)
   begin : g_bad_params
      $error("adc_capture: illegal parameter combination");
   end

   adc_state_e      state_q, state_d;
   time_format_t    time_next_q, time_next_d, period_q, period_d, time_diff_c;
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
   logic [15:0]     overflow_d;
   logic [DW-1:0]   codes_c;
   logic [EW-1:0]   wr_entry_c, head_c;
   logic [EW-1:0]   mem [DEPTH];
   logic            event_c, full_c, pop_c, push_c, drop_c;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      adc_quantize #(.SIG_BITS(SIG_BITS), .OUT_BITS(OUT_BITS)) u_quant (
         .sample (sig[i*SIG_BITS +: SIG_BITS]),
         .code_c (codes_c[i*OUT_BITS +: OUT_BITS])
      );
   end

   // Wrap-safe "time reached": the modular difference is non-negative
   assign time_diff_c = time_curr - time_next_q;
   assign event_c     = (state_q == CAPTURE) && ($signed(time_diff_c) >= 0);
   assign wr_entry_c  = {codes_c, time_curr};
   assign full_c      = (count == (AW+1)'(DEPTH));
   assign pop_c       = rd_valid && rd_ready;
   assign push_c      = event_c && !flush && (!mode || !full_c || pop_c);
   assign drop_c      = push_c && full_c && !pop_c;
   assign state       = state_q;

   // Pointer, occupancy and head-of-queue update, including write-through to an empty head
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow;
      if (push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_c || drop_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (drop_c && overflow != 16'hFFFF) overflow_d = overflow + 16'd1;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = '0;
      end
      count_d = wr_ptr_d - rd_ptr_d;
      head_c  = mem[rd_ptr_d[AW-1:0]];
      if (push_c && wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]) head_c = wr_entry_c;
   end

   // Capture FSM and sample-instant bookkeeping
   always_comb begin
      state_d     = state_q;
      time_next_d = time_next_q;
      period_d    = period_q;
      if (event_c) time_next_d = time_next_q + period_q;
      case (state_q)
         IDLE:    if (arm) state_d = ARMED;
         ARMED: begin
            state_d     = CAPTURE;
            time_next_d = time_curr;
            period_d    = t_period;
         end
         CAPTURE: if (mode && count_d == (AW+1)'(DEPTH)) state_d = DONE;
         DONE:    if (arm) state_d = ARMED;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         time_next_q <= '0;
         period_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count       <= '0;
         overflow    <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_time     <= '0;
      end else begin
         state_q     <= state_d;
         time_next_q <= time_next_d;
         period_q    <= period_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count       <= count_d;
         overflow    <= overflow_d;
         rd_valid    <= (count_d != '0);
         if (count_d != '0) {rd_data, rd_time} <= head_c;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr_q[AW-1:0]] <= wr_entry_c;
   end

endmodule
